qam_symbol_scheduler: RTL and testbench

QAM_SYMBOL_SCHEDULER -- requirements
Module: qam_symbol_scheduler

---
 rtl/qam_pkg.sv | 6 +
 rtl/qam_byte_fifo.sv | 39 +++
 rtl/qam_symbol_scheduler.sv | 101 ++++++++++
 tb/tb_qam_symbol_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// qam_pkg: shared state encoding and preamble symbols for the QAM symbol scheduler
package qam_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_e;
  localparam logic [1:0] PRE_HI = 2'b11;
  localparam logic [1:0] PRE_LO = 2'b00;
endpackage

// File: rtl/qam_byte_fifo.sv
// qam_byte_fifo: 2-deep byte FIFO with flush; push while full is taken only alongside a pop
module qam_byte_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  logic [7:0] mem_q [2];
  logic       wp_q, rp_q, do_push, do_pop;
  logic [1:0] cnt_q;
  assign full_o  = cnt_q[1];
  assign empty_o = cnt_q == 2'd0;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wp_q  <= wp_q ^ do_push;
      rp_q  <= rp_q ^ do_pop;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: frames queued bytes into bursts of alternating preamble symbols
// followed by MSB-first dibits, each symbol held for SPS clocks
module qam_symbol_scheduler
  import qam_pkg::*;
#(
  parameter int SPS          = 16,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       abort,
  output logic [1:0] data_out,
  output logic       tx_en,
  output logic       symbol_strobe,
  output logic       burst_done
);
  localparam int SW = $clog2(SPS);
  localparam int PW = PREAMBLE_LEN > 1 ? $clog2(PREAMBLE_LEN) : 1;
  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    dib_q, dib_d, data_q, data_d;
  logic [7:0]    sh_q, sh_d, head;
  logic          done_q, done_d, rdy_q, full, empty, last, push, pop;
  assign last          = cnt_q == SW'(SPS - 1);
  assign byte_ready    = rdy_q && !full && !abort;
  assign push          = byte_valid && byte_ready;
  assign pop           = state_q == DATA && cnt_q == '0 && dib_q == 2'd0 && !abort;
  assign data_out      = data_q;
  assign tx_en         = state_q != IDLE;
  assign symbol_strobe = state_q != IDLE && cnt_q == '0;
  assign burst_done    = done_q;
  qam_byte_fifo u_fifo (
    .clk(clk), .rst(rst), .flush_i(abort), .push_i(push), .din_i(byte_in),
    .pop_i(pop), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  // The head byte is latched into sh_q when its first dibit goes out; the pop follows a cycle later
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    pre_d   = pre_q;
    dib_d   = dib_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
      dib_d   = 2'd0;
      data_d  = 2'b00;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      if (!empty) begin
        state_d = PREAMBLE;
        pre_d   = '0;
        data_d  = PRE_HI;
      end
    end else if (last) begin
      if (state_q == PREAMBLE && pre_q != PW'(PREAMBLE_LEN - 1)) begin
        pre_d  = pre_q + 1'b1;
        data_d = pre_q[0] ? PRE_HI : PRE_LO;
      end else if (state_q == PREAMBLE || dib_q == 2'd3) begin
        dib_d   = 2'd0;
        pre_d   = '0;
        state_d = empty ? IDLE : DATA;
        data_d  = empty ? 2'b00 : head[7:6];
        sh_d    = {head[5:0], 2'b00};
        done_d  = empty;
      end else begin
        dib_d  = dib_q + 2'd1;
        data_d = sh_q[7:6];
        sh_d   = {sh_q[5:0], 2'b00};
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      dib_q   <= 2'd0;
      sh_q    <= 8'd0;
      data_q  <= 2'b00;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      dib_q   <= dib_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb_qam_symbol_scheduler: randomized bursts checked against an edge-indexed schedule model
module tb_qam_symbol_scheduler;
  localparam int SPS = 4;
  localparam int PL  = 2;
  logic       clk = 1'b0, rst = 1'b1, byte_valid = 1'b0, abort = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_ready, tx_en, symbol_strobe, burst_done;
  logic [1:0] data_out;
  qam_symbol_scheduler #(.SPS(SPS), .PREAMBLE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .abort(abort), .data_out(data_out), .tx_en(tx_en), .symbol_strobe(symbol_strobe),
    .burst_done(burst_done)
  );
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;
  typedef struct {int start; logic [1:0] sym;} sym_t;
  sym_t sq[$];
  int   dq[$];
  int   pq[$];
  int   busy_end = 0, air_start = 0, occ = 0, errors = 0, checks = 0;
  logic [1:0] cur_sym = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Schedule model: a byte accepted at edge a either extends the running burst or opens a new one at a+1
  task automatic model_accept(input int a, input logic [7:0] b);
    int d;
    if (a < busy_end) begin
      d = busy_end;
      if (dq.size() > 0 && dq[dq.size()-1] == busy_end) dq[dq.size()-1] = busy_end + 4*SPS;
    end else begin
      air_start = a + 1;
      for (int i = 0; i < PL; i++) sq.push_back('{a + 1 + i*SPS, (i % 2 == 0) ? 2'b11 : 2'b00});
      d = a + 1 + PL*SPS;
      dq.push_back(d + 4*SPS);
    end
    for (int i = 0; i < 4; i++) sq.push_back('{d + i*SPS, b[7-2*i -: 2]});
    pq.push_back(d + 1);
    busy_end = d + 4*SPS;
  endtask

  task automatic model_abort(input int x);
    while (sq.size() > 0 && sq[$].start >= x) void'(sq.pop_back());
    while (dq.size() > 0 && dq[$] >= x) void'(dq.pop_back());
    while (pq.size() > 0 && pq[$] >= x) void'(pq.pop_back());
    busy_end = 0;
  endtask

  task automatic model_reset();
    sq.delete();
    dq.delete();
    pq.delete();
    busy_end = 0;
    occ = 0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] b, input logic ab, output logic acc);
    int e;
    byte_valid = v;
    byte_in    = b;
    abort      = ab;
    #1;
    chk("byte_ready", byte_ready, !ab && occ < 2);
    acc = v && byte_ready;
    e = edge_n + 1;
    if (ab) model_abort(e);
    else if (acc) model_accept(e, b);
    @(negedge clk);
    if (ab) occ = 0;
    else if (acc) occ++;
    while (pq.size() > 0 && pq[0] <= e) begin
      void'(pq.pop_front());
      occ--;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, b, 1'b0, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %0h: not accepted within 200 cycles", b);
    end
  endtask

  always @(negedge clk) begin
    logic es, ed, tx;
    sym_t s;
    int   ev;
    if (!rst) begin
      ev = edge_n;
      while (sq.size() > 0 && sq[0].start < ev) begin
        s = sq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_symbol: symbol %0b due at edge %0d, now %0d", s.sym, s.start, ev);
      end
      while (dq.size() > 0 && dq[0] < ev) begin
        checks++;
        errors++;
        $display("FAIL missed_done: burst_done due at edge %0d, now %0d", dq.pop_front(), ev);
      end
      es = sq.size() > 0 && sq[0].start == ev;
      chk("symbol_strobe", symbol_strobe, es);
      if (es) begin
        s = sq.pop_front();
        chk("symbol_value", data_out, s.sym);
        cur_sym = s.sym;
      end
      tx = ev >= air_start && ev < busy_end;
      chk("tx_en", tx_en, tx);
      chk("data_out_hold", data_out, tx ? cur_sym : 2'b00);
      ed = dq.size() > 0 && dq[0] == ev;
      chk("burst_done", burst_done, ed);
      if (ed) void'(dq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   r;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 2'b00);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_strobe", symbol_strobe, 1'b0);
    chk("rst_done", burst_done, 1'b0);
    chk("rst_ready", byte_ready, 1'b0);
    rst = 1'b0;
    #1 chk("ready_before_edge", byte_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", byte_ready, 1'b1);
    send(8'hB4);
    idle(30);
    send(8'hFF);
    send(8'h00);
    send(8'h1B);
    idle(60);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    idle(100);
    send(8'h96);
    idle(5);
    cycle(1'b0, 8'd0, 1'b1, acc);
    idle(4);
    send(8'h5A);
    idle(40);
    send(8'h81);
    while (edge_n + 1 < busy_end) cycle(1'b0, 8'd0, 1'b0, acc);
    send(8'h7E);
    idle(50);
    send(8'h11);
    while (edge_n + 2 < busy_end) cycle(1'b0, 8'd0, 1'b0, acc);
    send(8'h22);
    idle(50);
    repeat (400) begin
      r = $urandom_range(0, 99);
      cycle(r < 60, 8'($urandom), r >= 97, acc);
    end
    idle(80);
    send(8'hC3);
    idle(12);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_data_out", data_out, 2'b00);
    chk("arst_tx_en", tx_en, 1'b0);
    chk("arst_strobe", symbol_strobe, 1'b0);
    chk("arst_ready", byte_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_ready_release", byte_ready, 1'b0);
    @(negedge clk);
    chk("arst_ready_after_edge", byte_ready, 1'b1);
    chk("arst_idle", tx_en, 1'b0);
    idle(10);
    send(8'hE1);
    idle(40);
    chk("symbols_left", sq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
